// File: rtl/i2c_pattern_monitor.sv
// Passive I2C monitor: oversamples SCL/SDA, finds START/STOP, deserialises bytes and
// checks the first NUM_BYTES bytes after each START against a runtime pattern/mask.
module i2c_pattern_monitor #(
    parameter int NUM_BYTES    = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int ACK_REQUIRED = 1,
    localparam int CW          = $clog2(NUM_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scl_in,
    input  logic                   sda_in,
    input  logic [NUM_BYTES*8-1:0] pattern,
    input  logic [NUM_BYTES*8-1:0] mask,
    output logic                   match,
    output logic                   mismatch,
    output logic                   busy,
    output logic                   byte_valid,
    output logic [7:0]             data_byte,
    output logic [CW-1:0]          byte_count,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2,
        SKIP  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_p_q;
    logic                   sda_p_q;
    logic [7:0]             shift_q;
    logic [7:0]             byte_q;
    logic [2:0]             bit_cnt_q;
    logic                   fail_q;
    logic                   busy_q;
    logic                   match_q;
    logic                   mismatch_q;
    logic                   byte_valid_q;
    logic [7:0]             data_byte_q;
    logic [CW-1:0]          byte_count_q;

    logic          scl_s;
    logic          sda_s;
    logic          scl_rise;
    logic          start_ev;
    logic          stop_ev;
    logic [7:0]    pat_sel;
    logic [7:0]    msk_sel;
    logic [7:0]    shift_d;
    logic          fail_d;
    logic          ack_bad_d;
    logic [CW-1:0] byte_count_d;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP need SCL steady high across both samples, so an SDA edge that lands
    // in the same sample as an SCL edge is never taken as a bus condition.
    assign scl_rise = scl_s & ~scl_p_q;
    assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;

    always_comb begin
        pat_sel = 8'h00;
        msk_sel = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_count_q == CW'(i)) begin
                pat_sel = pattern[(NUM_BYTES-1-i)*8 +: 8];
                msk_sel = mask[(NUM_BYTES-1-i)*8 +: 8];
            end
        end
    end

    assign shift_d      = {shift_q[6:0], sda_s};
    assign fail_d       = ((shift_d ^ pat_sel) & msk_sel) != 8'h00;
    assign ack_bad_d    = (ACK_REQUIRED != 0) && sda_s;
    assign byte_count_d = byte_count_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            byte_q       <= 8'h00;
            bit_cnt_q    <= 3'd0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            data_byte_q  <= 8'h00;
            byte_count_q <= '0;
        end else begin
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_p_q      <= scl_s;
            sda_p_q      <= sda_s;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            byte_valid_q <= 1'b0;

            if (start_ev) begin
                busy_q       <= 1'b1;
                state_q      <= SHIFT;
                bit_cnt_q    <= 3'd0;
                byte_count_q <= '0;
                fail_q       <= 1'b0;
            end else if (stop_ev) begin
                busy_q    <= 1'b0;
                state_q   <= IDLE;
                bit_cnt_q <= 3'd0;
            end else if (scl_rise) begin
                case (state_q)
                    SHIFT: begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_q  <= shift_d;
                            fail_q  <= fail_d;
                            state_q <= ACK;
                        end
                    end
                    ACK: begin
                        byte_valid_q <= 1'b1;
                        data_byte_q  <= byte_q;
                        if (fail_q || ack_bad_d) begin
                            mismatch_q <= 1'b1;
                            state_q    <= SKIP;
                        end else begin
                            byte_count_q <= byte_count_d;
                            if (byte_count_d == CW'(NUM_BYTES)) begin
                                match_q <= 1'b1;
                                state_q <= SKIP;
                            end else begin
                                state_q   <= SHIFT;
                                bit_cnt_q <= 3'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign match      = match_q;
    assign mismatch   = mismatch_q;
    assign busy       = busy_q;
    assign byte_valid = byte_valid_q;
    assign data_byte  = data_byte_q;
    assign byte_count = byte_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_i2c_pattern_monitor.sv
// Bench for i2c_pattern_monitor: bit-banged I2C master, event scoreboard per DUT,
// scenario tasks with inline checks of busy/state/byte_count.
module tb_i2c_pattern_monitor;

  localparam int Q = 40;  // quarter SCL period; SCL = 16 clk periods

  logic        clk;
  logic        reset;
  logic        reset_na;
  logic        scl;
  logic        sda;
  logic [15:0] pattern;
  logic [15:0] mask;

  logic       match, mismatch, busy, byte_valid;
  logic [7:0] data_byte;
  logic [1:0] byte_count;
  logic [1:0] state;

  logic       na_match, na_mismatch, na_busy, na_byte_valid;
  logic [7:0] na_data_byte;
  logic [1:0] na_byte_count;
  logic [1:0] na_state;

  int total = 0;
  int bad = 0;

  // Event tokens: {kind, count, data}; kind 1 = byte, 2 = match, 3 = mismatch
  logic [15:0] exp_q[$];
  logic [15:0] exp_na_q[$];

  i2c_pattern_monitor #(.NUM_BYTES(2), .SYNC_STAGES(2), .ACK_REQUIRED(1)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda),
    .pattern(pattern), .mask(mask),
    .match(match), .mismatch(mismatch), .busy(busy), .byte_valid(byte_valid),
    .data_byte(data_byte), .byte_count(byte_count), .state(state)
  );

  i2c_pattern_monitor #(.NUM_BYTES(2), .SYNC_STAGES(2), .ACK_REQUIRED(0)) dut_na (
    .clk(clk), .reset(reset_na), .scl_in(scl), .sda_in(sda),
    .pattern(pattern), .mask(mask),
    .match(na_match), .mismatch(na_mismatch), .busy(na_busy), .byte_valid(na_byte_valid),
    .data_byte(na_data_byte), .byte_count(na_byte_count), .state(na_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (match || mismatch) begin
      total++;
      if (match && mismatch) begin
        bad++;
        $display("FAIL both_pulses: match=%0b mismatch=%0b want only one", match, mismatch);
      end
    end
    if (byte_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got data=%h count=%0d want no event", data_byte, byte_count);
      end else begin
        e = exp_q.pop_front();
        if ({4'h1, 4'(byte_count), data_byte} !== e)
          begin bad++; $display("FAIL byte_event: got %h want %h", {4'h1, 4'(byte_count), data_byte}, e); end
      end
    end
    if (match) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL unexpected_match: got match want none"); end
      else begin
        e = exp_q.pop_front();
        if (16'h2000 !== e) begin bad++; $display("FAIL match_event: got 2000 want %h", e); end
      end
    end
    if (mismatch) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL unexpected_mismatch: got mismatch want none"); end
      else begin
        e = exp_q.pop_front();
        if (16'h3000 !== e) begin bad++; $display("FAIL mismatch_event: got 3000 want %h", e); end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (na_byte_valid) begin
      total++;
      if (exp_na_q.size() == 0) begin bad++; $display("FAIL na_unexpected_byte: got %h want none", na_data_byte); end
      else begin
        e = exp_na_q.pop_front();
        if ({4'h1, 4'(na_byte_count), na_data_byte} !== e)
          begin bad++; $display("FAIL na_byte_event: got %h want %h", {4'h1, 4'(na_byte_count), na_data_byte}, e); end
      end
    end
    if (na_match) begin
      total++;
      if (exp_na_q.size() == 0) begin bad++; $display("FAIL na_unexpected_match: got match want none"); end
      else begin
        e = exp_na_q.pop_front();
        if (16'h2000 !== e) begin bad++; $display("FAIL na_match_event: got 2000 want %h", e); end
      end
    end
    if (na_mismatch) begin
      total++;
      if (exp_na_q.size() == 0) begin bad++; $display("FAIL na_unexpected_mismatch: got mismatch want none"); end
      else begin
        e = exp_na_q.pop_front();
        if (16'h3000 !== e) begin bad++; $display("FAIL na_mismatch_event: got 3000 want %h", e); end
      end
    end
  end

  // ---------------- bus driver tasks ----------------
  task automatic send_start();
    if (scl == 1'b0) begin
      sda = 1'b1; #Q;
      scl = 1'b1; #Q;
    end
    sda = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda = b;    #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic nack);
    send_bits(b, 8);
    send_bit(nack);
  endtask

  task automatic send_stop();
    sda = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda = 1'b1; #Q;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    total++;
    if (busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL %s_idle: got busy=%0b state=%0d want busy=0 state=0", name, busy, state);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending events want 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    reset_na = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({match, mismatch, busy, byte_valid, data_byte, byte_count, state} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got m=%0b mm=%0b busy=%0b bv=%0b db=%h cnt=%0d st=%0d want all 0",
               match, mismatch, busy, byte_valid, data_byte, byte_count, state);
    end
    settle();
  endtask

  task automatic test_match();
    exp_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_q.push_back({4'h1, 4'd2, 8'h3C});
    exp_q.push_back(16'h2000);
    send_start();
    total++;
    if (busy !== 1'b1 || state !== 2'd1) begin
      bad++;
      $display("FAIL match_busy: got busy=%0b state=%0d want busy=1 state=1", busy, state);
    end
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    total++;
    if (state !== 2'd3) begin bad++; $display("FAIL match_skip: got state=%0d want 3", state); end
    send_stop();
    settle();
    check_idle("match");
  endtask

  task automatic test_mismatch();
    exp_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_q.push_back({4'h1, 4'd1, 8'h3D});
    exp_q.push_back(16'h3000);
    send_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3D, 1'b0);
    send_byte(8'h3C, 1'b0);
    total++;
    if (state !== 2'd3 || byte_count !== 2'd1) begin
      bad++;
      $display("FAIL mismatch_skip: got state=%0d cnt=%0d want state=3 cnt=1", state, byte_count);
    end
    send_stop();
    settle();
    check_idle("mismatch");
  endtask

  task automatic test_mask();
    mask = 16'hFFF0;
    exp_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_q.push_back({4'h1, 4'd2, 8'h3D});
    exp_q.push_back(16'h2000);
    send_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3D, 1'b0);
    send_stop();
    settle();
    check_idle("mask");
    mask = 16'hFFFF;
  endtask

  task automatic test_nack();
    @(negedge clk);
    reset_na = 1'b0;
    exp_q.push_back({4'h1, 4'd0, 8'hA0});
    exp_q.push_back(16'h3000);
    exp_na_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_na_q.push_back({4'h1, 4'd2, 8'h3C});
    exp_na_q.push_back(16'h2000);
    send_start();
    send_byte(8'hA0, 1'b1);
    total++;
    if (byte_count !== 2'd0 || state !== 2'd3) begin
      bad++;
      $display("FAIL nack_count: got cnt=%0d state=%0d want cnt=0 state=3", byte_count, state);
    end
    send_byte(8'h3C, 1'b1);
    send_stop();
    settle();
    check_idle("nack");
    total++;
    if (exp_na_q.size() != 0 || na_busy !== 1'b0) begin
      bad++;
      $display("FAIL na_drain: got %0d pending busy=%0b want 0 pending busy=0", exp_na_q.size(), na_busy);
    end
    reset_na = 1'b1;
  endtask

  task automatic test_restart();
    exp_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_q.push_back({4'h1, 4'd1, 8'hA0});
    exp_q.push_back({4'h1, 4'd2, 8'h3C});
    exp_q.push_back(16'h2000);
    send_start();
    send_byte(8'hA0, 1'b0);
    send_bits(8'h3C, 4);
    send_start();
    total++;
    if (byte_count !== 2'd0 || state !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: got cnt=%0d state=%0d busy=%0b want cnt=0 state=1 busy=1",
               byte_count, state, busy);
    end
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_stop();
    settle();
    check_idle("restart");
    send_start();
    send_bits(8'hA0, 4);
    send_stop();
    settle();
    check_idle("partial");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] b1;
      b1 = (n == 1) ? 8'h3C ^ 8'(1 << $urandom_range(0, 7)) : 8'h3C;
      exp_q.push_back({4'h1, 4'd1, 8'hA0});
      exp_q.push_back({4'h1, (b1 == 8'h3C) ? 4'd2 : 4'd1, b1});
      exp_q.push_back((b1 == 8'h3C) ? 16'h2000 : 16'h3000);
      send_start();
      send_byte(8'hA0, 1'b0);
      send_byte(b1, 1'b0);
      send_stop();
      settle();
    end
    check_idle("b2b");
  endtask

  task automatic test_mid_reset();
    send_start();
    send_bits(8'hA0, 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({match, mismatch, busy, byte_valid, data_byte, byte_count, state} !== 14'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got m=%0b mm=%0b busy=%0b bv=%0b db=%h cnt=%0d st=%0d want all 0",
               match, mismatch, busy, byte_valid, data_byte, byte_count, state);
    end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h3C, 1'b0);
    send_bits(8'hA0, 8);
    total++;
    if (state !== 2'd0 || byte_count !== 2'd0 || data_byte !== 8'h00) begin
      bad++;
      $display("FAIL midreset_ignore: got state=%0d cnt=%0d db=%h want 0 0 00", state, byte_count, data_byte);
    end
    send_stop();
    settle();
    check_idle("midreset");
  endtask

  // ---------------- sequence ----------------
  initial begin
    scl = 1'b1;
    sda = 1'b1;
    pattern = 16'hA03C;
    mask = 16'hFFFF;
    reset = 1'b1;
    reset_na = 1'b1;
    test_reset();
    test_match();
    test_mismatch();
    test_mask();
    test_nack();
    test_restart();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
